// File: rtl/mul_seq.sv
// Sequential shift-and-add unsigned multiplier: one N-bit adder, N RUN cycles
// per product, then a single-cycle DONE pulse with the registered 2N-bit result.

module ADD #(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out
);

  assign {c_out, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};

endmodule

module mul_seq #(
  parameter int N = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  state_t         state_nx;
  logic [N-1:0]   m;
  logic [N-1:0]   hi;
  logic [N-1:0]   lo;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   addend;
  logic [N-1:0]   sum;
  logic           carry;
  logic           last;
  logic [N-1:0]   hi_nx;
  logic [N-1:0]   lo_nx;

  assign last   = (cnt == CW'(N - 1));
  assign addend = lo[0] ? m : '0;

  ADD #(.N(N)) u_add (
    .a     (hi),
    .b     (addend),
    .c_in  (1'b0),
    .s     (sum),
    .c_out (carry)
  );

  // {carry, sum, lo} >> 1, split back into the HI and LO halves
  assign hi_nx = {carry, sum[N-1:1]};
  assign lo_nx = {sum[0], lo[N-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m       <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            m   <= a;
            hi  <= '0;
            lo  <= b;
            cnt <= '0;
          end
        end
        RUN: begin
          hi <= hi_nx;
          lo <= lo_nx;
          // Counter holds on the final step so it never wraps for N a power of two
          if (last) begin
            product <= {hi_nx, lo_nx};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed and random checks of mul_seq (N=64): latency, busy window,
// start handling, reset abort and products against a 128-bit reference.

module tb_mul_seq;

  localparam int N = 64;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int n_cmp = 0;
  int n_bad = 0;
  logic prev_done = 1'b0;

  mul_seq #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_cmp++;
      if (prev_done === 1'b1) begin
        n_bad++;
        $display("FAIL done_consecutive: done high in two consecutive cycles at %0t", $time);
      end
    end
    prev_done = done;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accepts one operation, scrambles a/b during RUN, optionally raises start
  // again in cycle poke_at, and reports what was observed up to busy falling.
  task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                        input int poke_at, input logic [N-1:0] pa, input logic [N-1:0] pb,
                        output logic [2*N-1:0] prod, output int lat,
                        output int bcyc, output int pulses);
    int j;
    a = av; b = bv; start = 1'b1;
    tick;
    start = 1'b0; a = ~av; b = ~bv;
    prod = '0; lat = -1; pulses = 0; j = 0;
    while (busy === 1'b1 && j < 300) begin
      if (done === 1'b1) begin
        lat = j; pulses++; prod = product;
      end
      if (j == poke_at) begin
        start = 1'b1; a = pa; b = pb;
      end else begin
        start = 1'b0;
      end
      tick;
      j++;
    end
    start = 1'b0;
    bcyc = j;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; a = 64'h5; b = 64'h7;
    tick; tick;
    rst = 1'b0; start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (product !== '0) begin n_bad++; $display("FAIL reset_product: got %h expected 0", product); end
  endtask

  task automatic test_directed;
    logic [N-1:0]   av [4];
    logic [N-1:0]   bv [4];
    logic [2*N-1:0] ev [4];
    logic [2*N-1:0] p;
    int lat, bc, pu;
    av[0] = 64'h0;  bv[0] = 64'h0;  ev[0] = 128'h0;
    av[1] = 64'h1;  bv[1] = 64'h1;  ev[1] = 128'h1;
    av[2] = 64'h11; bv[2] = 64'h11; ev[2] = 128'h121;
    av[3] = 64'hFFFF_FFFF_FFFF_FFFF; bv[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    ev[3] = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
    for (int i = 0; i < 4; i++) begin
      run_op(av[i], bv[i], -1, '0, '0, p, lat, bc, pu);
      n_cmp++; if (p !== ev[i]) begin n_bad++; $display("FAIL dir%0d_product: got %h expected %h", i, p, ev[i]); end
      n_cmp++; if (lat != N) begin n_bad++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, N); end
      n_cmp++; if (bc != N + 1) begin n_bad++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, bc, N + 1); end
      n_cmp++; if (pu != 1) begin n_bad++; $display("FAIL dir%0d_pulses: got %0d expected 1", i, pu); end
      tick;
      n_cmp++; if (product !== ev[i]) begin n_bad++; $display("FAIL dir%0d_hold: got %h expected %h", i, product, ev[i]); end
    end
  endtask

  task automatic test_ignore_start;
    logic [2*N-1:0] p;
    int lat, bc, pu;
    run_op(64'd3, 64'd5, 9, 64'd7, 64'd7, p, lat, bc, pu);
    n_cmp++; if (p !== 128'd15) begin n_bad++; $display("FAIL ignore_product: got %h expected %h", p, 128'd15); end
    n_cmp++; if (pu != 1) begin n_bad++; $display("FAIL ignore_pulses: got %0d expected 1", pu); end
    n_cmp++; if (lat != N) begin n_bad++; $display("FAIL ignore_latency: got %0d expected %0d", lat, N); end
    tick; tick;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_no_queue: busy %b expected 0", busy); end
  endtask

  task automatic test_reset_mid;
    logic [2*N-1:0] p;
    int lat, bc, pu, seen;
    a = 64'd9; b = 64'd9; start = 1'b1;
    tick;
    start = 1'b0;
    for (int j = 0; j < 29; j++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b expected 0", done); end
    n_cmp++; if (product !== '0) begin n_bad++; $display("FAIL rstmid_product: got %h expected 0", product); end
    seen = 0;
    for (int j = 0; j < 80; j++) begin
      if (done === 1'b1) seen++;
      tick;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", seen); end
    run_op(64'd2, 64'd3, -1, '0, '0, p, lat, bc, pu);
    n_cmp++; if (p !== 128'd6) begin n_bad++; $display("FAIL rstmid_next_product: got %h expected %h", p, 128'd6); end
    n_cmp++; if (lat != N) begin n_bad++; $display("FAIL rstmid_next_latency: got %0d expected %0d", lat, N); end
  endtask

  task automatic test_back_to_back;
    int t, cnt;
    int times [3];
    a = 64'd5; b = 64'd6; start = 1'b1;
    t = 0; cnt = 0;
    while (cnt < 3 && t < 300) begin
      tick;
      t++;
      if (done === 1'b1) begin
        times[cnt] = t;
        cnt++;
        n_cmp++; if (product !== 128'd30) begin n_bad++; $display("FAIL b2b_product: got %h expected %h", product, 128'd30); end
      end
    end
    start = 1'b0;
    n_cmp++; if (cnt != 3) begin n_bad++; $display("FAIL b2b_pulse_count: got %0d expected 3", cnt); end
    if (cnt == 3) begin
      // DONE -> IDLE takes one edge, the next accept is the following edge
      n_cmp++; if (times[1] - times[0] != N + 2) begin n_bad++; $display("FAIL b2b_period1: got %0d expected %0d", times[1] - times[0], N + 2); end
      n_cmp++; if (times[2] - times[1] != N + 2) begin n_bad++; $display("FAIL b2b_period2: got %0d expected %0d", times[2] - times[1], N + 2); end
    end
    for (int j = 0; j < 80 && busy === 1'b1; j++) tick;
    tick;
  endtask

  task automatic test_random;
    logic [N-1:0]   ra, rb;
    logic [2*N-1:0] p, ref_p;
    int lat, bc, pu;
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 50 == 0) ra = '1;
      if (i % 70 == 1) rb = '1;
      ref_p = {{N{1'b0}}, ra} * {{N{1'b0}}, rb};
      run_op(ra, rb, -1, '0, '0, p, lat, bc, pu);
      n_cmp++;
      if (p !== ref_p || lat != N || pu != 1) begin
        n_bad++;
        $display("FAIL rand%0d: a=%h b=%h got %h lat %0d pulses %0d expected %h lat %0d pulses 1",
                 i, ra, rb, p, lat, pu, ref_p, N);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset;
    test_directed;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    test_random;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
